// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : LC-3b instruction fetch with PC, IF/ID register, stall and redirect
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ifid_valid,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_ir,
    output logic [3:0]  opcode,
    output logic        ir5,
    output logic        ir11
);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] drain_addr;
    logic [15:0] hold_ir;
    logic [15:0] hold_pc;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc + 16'd2;

    // Outputs decode registered state only, so they move solely on clock edges.
    assign imem_read    = (state == FETCH) || (state == DRAIN);
    assign imem_address = (state == DRAIN) ? {drain_addr[15:1], 1'b0} : {pc[15:1], 1'b0};

    assign opcode = ifid_ir[15:12];
    assign ir5    = ifid_ir[5];
    assign ir11   = ifid_ir[11];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= START;
            pc         <= RESET_PC;
            drain_addr <= 16'h0000;
            hold_ir    <= 16'h0000;
            hold_pc    <= 16'h0000;
            ifid_valid <= 1'b0;
            ifid_pc    <= 16'h0000;
            ifid_ir    <= 16'h0000;
        end else begin
            case (state)
                START: begin
                    if (redirect)
                        pc <= redirect_pc;
                    state <= FETCH;
                end

                FETCH: begin
                    if (redirect) begin
                        pc         <= redirect_pc;
                        ifid_valid <= 1'b0;
                        ifid_pc    <= 16'h0000;
                        ifid_ir    <= 16'h0000;
                        if (!imem_resp) begin
                            // Outstanding request must complete before retargeting.
                            drain_addr <= pc;
                            state      <= DRAIN;
                        end
                    end else if (imem_resp) begin
                        pc <= pc_plus2;
                        if (!stall) begin
                            ifid_valid <= 1'b1;
                            ifid_pc    <= pc_plus2;
                            ifid_ir    <= imem_rdata;
                        end else begin
                            hold_ir <= imem_rdata;
                            hold_pc <= pc_plus2;
                            state   <= HOLD;
                        end
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_ir    <= 16'h0000;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc         <= redirect_pc;
                        ifid_valid <= 1'b0;
                        ifid_pc    <= 16'h0000;
                        ifid_ir    <= 16'h0000;
                        state      <= FETCH;
                    end else if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_pc    <= hold_pc;
                        ifid_ir    <= hold_ir;
                        state      <= FETCH;
                    end
                end

                DRAIN: begin
                    if (redirect) begin
                        pc         <= redirect_pc;
                        ifid_valid <= 1'b0;
                        ifid_pc    <= 16'h0000;
                        ifid_ir    <= 16'h0000;
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_ir    <= 16'h0000;
                    end
                    if (imem_resp)
                        state <= FETCH;
                end

                default: state <= START;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ifid_valid;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_ir;
    logic [3:0]  opcode;
    logic        ir5;
    logic        ir11;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .ifid_valid   (ifid_valid),
        .ifid_pc      (ifid_pc),
        .ifid_ir      (ifid_ir),
        .opcode       (opcode),
        .ir5          (ir5),
        .ir11         (ir11)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [15:0] p, input logic [15:0] ir);
        check({tag, "_valid"}, {15'd0, ifid_valid}, {15'd0, v});
        check({tag, "_pc"}, ifid_pc, p);
        check({tag, "_ir"}, ifid_ir, ir);
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_resp   = 1'b1;
        imem_rdata  = 16'h1111;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        step();
        step();

        // Reset state
        check("rst_read", {15'd0, imem_read}, 16'h0000);
        check("rst_addr", imem_address, 16'h0000);
        check("rst_opcode", {12'd0, opcode}, 16'h0000);
        check("rst_ir5_ir11", {14'd0, ir5, ir11}, 16'h0000);
        check_ifid("rst", 1'b0, 16'h0000, 16'h0000);

        // Release mid-cycle; START holds the read off for one cycle
        rst_n = 1'b1;
        #1;
        check("start_read", {15'd0, imem_read}, 16'h0000);
        step();
        check("fetch0_read", {15'd0, imem_read}, 16'h0001);
        check("fetch0_addr", imem_address, 16'h0000);
        check("fetch0_valid", {15'd0, ifid_valid}, 16'h0000);

        // Zero-wait sequential fetch
        imem_rdata = 16'h1234;
        step();
        check_ifid("seq1", 1'b1, 16'h0002, 16'h1234);
        check("seq1_addr", imem_address, 16'h0002);
        imem_rdata = 16'h2345;
        step();
        check_ifid("seq2", 1'b1, 16'h0004, 16'h2345);
        check("seq2_addr", imem_address, 16'h0004);

        // Multi-cycle memory: two bubbles with the address held
        imem_resp = 1'b0;
        step();
        check_ifid("mc_bub1", 1'b0, 16'h0004, 16'h0000);
        check("mc_addr1", imem_address, 16'h0004);
        step();
        check_ifid("mc_bub2", 1'b0, 16'h0004, 16'h0000);
        check("mc_addr2", imem_address, 16'h0004);
        check("mc_read2", {15'd0, imem_read}, 16'h0001);
        imem_resp  = 1'b1;
        imem_rdata = 16'h3456;
        step();
        check_ifid("mc_data", 1'b1, 16'h0006, 16'h3456);
        check("mc_next", imem_address, 16'h0006);

        // Advance to pc=0010
        for (int i = 0; i < 5; i++) begin
            imem_rdata = 16'h4000 + 16'(i);
            step();
            check("adv_pc", ifid_pc, 16'h0008 + 16'(2 * i));
        end
        check("adv_addr", imem_address, 16'h0010);

        // Stall at response
        stall      = 1'b1;
        imem_rdata = 16'h5555;
        step();
        check_ifid("st1", 1'b1, 16'h0010, 16'h4004);
        check("st1_read", {15'd0, imem_read}, 16'h0000);
        imem_resp = 1'b0;
        step();
        check_ifid("st2", 1'b1, 16'h0010, 16'h4004);
        check("st2_read", {15'd0, imem_read}, 16'h0000);
        stall = 1'b0;
        step();
        check_ifid("st_rel", 1'b1, 16'h0012, 16'h5555);
        check("st_rel_addr", imem_address, 16'h0012);
        check("st_rel_read", {15'd0, imem_read}, 16'h0001);

        // Redirect with a response present: next request at target
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        imem_resp   = 1'b1;
        imem_rdata  = 16'h6666;
        step();
        check_ifid("rd_resp", 1'b0, 16'h0000, 16'h0000);
        check("rd_resp_addr", imem_address, 16'h0020);

        // Redirect while a request to 0020 is outstanding
        redirect  = 1'b0;
        imem_resp = 1'b0;
        step();
        check("wait_addr", imem_address, 16'h0020);
        redirect    = 1'b1;
        redirect_pc = 16'h0400;
        step();
        check("drain_addr1", imem_address, 16'h0020);
        check("drain_read1", {15'd0, imem_read}, 16'h0001);
        check("drain_valid1", {15'd0, ifid_valid}, 16'h0000);
        redirect = 1'b0;
        step();
        check("drain_addr2", imem_address, 16'h0020);
        imem_resp  = 1'b1;
        imem_rdata = 16'h7777;
        step();
        check_ifid("drain_done", 1'b0, 16'h0000, 16'h0000);
        check("drain_target", imem_address, 16'h0400);
        imem_rdata = 16'h8888;
        step();
        check_ifid("after_drain", 1'b1, 16'h0402, 16'h8888);

        // Redirect while in HOLD with stall asserted
        stall      = 1'b1;
        imem_rdata = 16'h9999;
        step();
        check_ifid("hold_in", 1'b1, 16'h0402, 16'h8888);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        imem_resp   = 1'b0;
        step();
        check_ifid("hold_rd", 1'b0, 16'h0000, 16'h0000);
        check("hold_rd_addr", imem_address, 16'h0100);
        check("hold_rd_read", {15'd0, imem_read}, 16'h0001);
        redirect   = 1'b0;
        stall      = 1'b0;
        imem_resp  = 1'b1;
        imem_rdata = 16'hAAAA;
        step();
        check_ifid("hold_lost", 1'b1, 16'h0102, 16'hAAAA);

        // Decode fields and PC wrap
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        check("wrap_addr", imem_address, 16'hFFFE);
        redirect   = 1'b0;
        imem_rdata = 16'h1A21;
        step();
        check("dec_opcode", {12'd0, opcode}, 16'h0001);
        check("dec_ir5", {15'd0, ir5}, 16'h0001);
        check("dec_ir11", {15'd0, ir11}, 16'h0001);
        check("wrap_ifid_pc", ifid_pc, 16'h0000);
        check("wrap_next", imem_address, 16'h0000);

        // Odd redirect target: bit 0 masked on the bus
        redirect    = 1'b1;
        redirect_pc = 16'h0301;
        step();
        check("odd_addr", imem_address, 16'h0300);

        // Asynchronous reset mid-request; response in START is ignored
        redirect  = 1'b0;
        imem_resp = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_read", {15'd0, imem_read}, 16'h0000);
        check("areset_addr", imem_address, 16'h0000);
        check("areset_valid", {15'd0, ifid_valid}, 16'h0000);
        step();
        rst_n      = 1'b1;
        imem_resp  = 1'b1;
        imem_rdata = 16'hBBBB;
        step();
        check_ifid("start_ignore", 1'b0, 16'h0000, 16'h0000);
        check("start_ignore_addr", imem_address, 16'h0000);
        step();
        check_ifid("restart", 1'b1, 16'h0002, 16'hBBBB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
